// File: rtl/board_io_pkg.sv
// board_io_pkg
// Shared definitions for the DE1-SoC board I/O controller:
//   - BLANK_SEG : seven-segment pattern with every segment off (active-low)
//   - mode_e    : switch-selected operating mode (control word / data entry)
//   - hex_to_seg: nibble to active-low gfedcba seven-segment font
package board_io_pkg;

    localparam logic [6:0] BLANK_SEG = 7'h7F;

    typedef enum logic {
        MODE_CTRL = 1'b0,
        MODE_DATA = 1'b1
    } mode_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Synchronises one active-low push-button and debounces it.
// Ports:
//   clk    in  board clock
//   reset  in  synchronous, active-high
//   key_n  in  raw button, active-low
//   press  out one-cycle strobe; the accepted level falls 1->0 on the
//              clock edge that ends the cycle in which press is high
//   level  out accepted (debounced) level, 1 = released
module key_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    logic             acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             armed_q;
    logic             key_s;
    logic             differ;
    logic             expire;

    assign key_s  = sync_q[1];
    assign differ = (key_s != acc_q);
    assign expire = differ && (cnt_q == CNT_LAST);

    // A press is only reported once the key has been seen released since
    // reset, so a key held through reset release cannot fire. The
    // synchroniser resets to "pressed" so that a held key never looks
    // released in the first cycles after reset.
    assign press = expire && acc_q && !key_s && armed_q;
    assign level = acc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b00;
            acc_q   <= 1'b1;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_n};
            if (key_s) begin
                armed_q <= 1'b1;
            end
            if (!differ) begin
                cnt_q <= '0;
            end else if (expire) begin
                cnt_q <= '0;
                acc_q <= key_s;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl
// Board-level I/O controller between the DE1-SoC pins and a datapath.
// KEY0 becomes a one-cycle datapath clock-enable (control mode) or a byte
// lane write strobe (data mode); KEY1 pages the seven-segment display.
// Ports:
//   clk          in  board clock
//   reset        in  synchronous, active-high
//   key_n[1:0]   in  raw buttons, active-low; [0] step, [1] page
//   sw[9:0]      in  raw switches; sw[9] = 1 data mode, 0 control mode
//   status       in  datapath status flag, shown on ledr[9]
//   datapath_out in  value shown on the seven-segment display
//   dp_en        out one-cycle datapath clock-enable
//   datapath_in  out byte-lane assembled datapath input
//   ctrl         out latched control word
//   lane         out byte lane written by the next data-mode step
//   ledr         out registered LED drive
//   hex          out registered active-low segments, digit 0 at [6:0]
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter  int DATA_W       = 16,
    parameter  int NUM_HEX      = 6,
    parameter  int DEBOUNCE_CYC = 500000,
    parameter  int CTRL_W       = 9,
    localparam int LANE_W       = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           key_n,
    input  logic [9:0]           sw,
    input  logic                 status,
    input  logic [DATA_W-1:0]    datapath_out,
    output logic                 dp_en,
    output logic [DATA_W-1:0]    datapath_in,
    output logic [CTRL_W-1:0]    ctrl,
    output logic [LANE_W-1:0]    lane,
    output logic [9:0]           ledr,
    output logic [7*NUM_HEX-1:0] hex
);

    localparam int NLANES = DATA_W / 8;
    localparam int NDIG   = DATA_W / 4;
    localparam int NPAGE  = (NDIG + NUM_HEX - 1) / NUM_HEX;
    localparam int PAGE_W = (NPAGE > 1) ? $clog2(NPAGE) : 1;

    logic [9:0]           sw_s1_q, sw_s2_q;
    logic                 mode_data_q;
    logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
    logic                 dp_en_q, dp_en_d;
    logic [LANE_W-1:0]    lane_q, lane_d, lane_eff;
    logic [DATA_W-1:0]    din_q, din_d;
    logic [PAGE_W-1:0]    page_q, page_d;
    logic [7*NUM_HEX-1:0] hex_q, hex_d;
    logic [9:0]           ledr_q, ledr_d;
    logic [8:0]           ctrl9;

    logic                 step_press, page_press;
    logic [1:0]           unused_key_level;
    mode_e                mode;
    logic                 mode_rise;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n[0]),
        .press (step_press),
        .level (unused_key_level[0])
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_page (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n[1]),
        .press (page_press),
        .level (unused_key_level[1])
    );

    assign mode      = sw_s2_q[9] ? MODE_DATA : MODE_CTRL;
    assign mode_rise = (mode == MODE_DATA) && !mode_data_q;
    // A step coinciding with entry into data mode writes lane 0.
    assign lane_eff  = mode_rise ? '0 : lane_q;

    generate
        if (CTRL_W >= 9) begin : g_ctrl_trunc
            assign ctrl9 = ctrl_q[8:0];
        end else begin : g_ctrl_ext
            assign ctrl9 = {{(9 - CTRL_W){1'b0}}, ctrl_q};
        end
    endgenerate

    always_comb begin
        ctrl_d  = ctrl_q;
        din_d   = din_q;
        lane_d  = lane_q;
        dp_en_d = 1'b0;
        if (mode == MODE_CTRL) begin
            ctrl_d  = sw_s2_q[CTRL_W-1:0];
            dp_en_d = step_press;
        end else begin
            lane_d = lane_eff;
            if (step_press) begin
                din_d[8*int'(lane_eff) +: 8] = sw_s2_q[7:0];
                lane_d = (lane_eff == LANE_W'(NLANES - 1)) ? '0 : lane_eff + LANE_W'(1);
            end
        end
    end

    // With a single page the wrap compare always hits, so paging is inert.
    always_comb begin
        page_d = page_q;
        if (page_press) begin
            page_d = (page_q == PAGE_W'(NPAGE - 1)) ? '0 : page_q + PAGE_W'(1);
        end
    end

    // Digits beyond the last nibble of datapath_out are blanked.
    always_comb begin
        hex_d = '0;
        for (int i = 0; i < NUM_HEX; i++) begin
            if (int'(page_q) * NUM_HEX + i < NDIG) begin
                hex_d[7*i +: 7] = hex_to_seg(datapath_out[4*(int'(page_q) * NUM_HEX + i) +: 4]);
            end else begin
                hex_d[7*i +: 7] = BLANK_SEG;
            end
        end
    end

    always_comb begin
        ledr_d    = '0;
        ledr_d[9] = status;
        if (mode == MODE_DATA) begin
            ledr_d[8:0] = ctrl9;
        end else begin
            ledr_d[8:0] = {1'b0, din_q[8*int'(lane_q) +: 8]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            mode_data_q <= 1'b0;
            ctrl_q      <= '0;
            dp_en_q     <= 1'b0;
            lane_q      <= '0;
            din_q       <= '0;
            page_q      <= '0;
            hex_q       <= {NUM_HEX{BLANK_SEG}};
            ledr_q      <= '0;
        end else begin
            sw_s1_q     <= sw;
            sw_s2_q     <= sw_s1_q;
            mode_data_q <= (mode == MODE_DATA);
            ctrl_q      <= ctrl_d;
            dp_en_q     <= dp_en_d;
            lane_q      <= lane_d;
            din_q       <= din_d;
            page_q      <= page_d;
            hex_q       <= hex_d;
            ledr_q      <= ledr_d;
        end
    end

    assign dp_en       = dp_en_q;
    assign datapath_in = din_q;
    assign ctrl        = ctrl_q;
    assign lane        = lane_q;
    assign ledr        = ledr_q;
    assign hex         = hex_q;

endmodule
